// File: rtl/icache_axi_refill_if.sv
// AXI4 read-address and read-data channels between the icache refill
// engine (master) and the interconnect (slave).
//
// Ports (modports):
//   master : drives AR payload, arvalid, rready; samples arready, R payload
//   slave  : mirror of master
interface icache_axi_refill_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid,
        output araddr,
        output arlen,
        output arsize,
        output arburst,
        output arvalid,
        input  arready,
        input  rid,
        input  rdata,
        input  rresp,
        input  rlast,
        input  rvalid,
        output rready
    );

    modport slave (
        input  arid,
        input  araddr,
        input  arlen,
        input  arsize,
        input  arburst,
        input  arvalid,
        output arready,
        output rid,
        output rdata,
        output rresp,
        output rlast,
        output rvalid,
        input  rready
    );
endinterface

// File: rtl/icache_axi_refill.sv
// Icache memory-side responder: turns a line refill or an uncached word
// fetch into one AXI4 read burst and hands back the line or the word.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   rd_req / rd_addr      : line refill request (level) and address
//   ret_valid / ret_data  : one-cycle pulse with the assembled 256-bit line
//   iucache_ren_i / _addr : uncached fetch request (level) and address
//   iucache_rvalid_o/_rdata_o : one-cycle pulse with the 32-bit word
//   axi                   : AXI4 AR/R master channels
module icache_axi_refill #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       rd_req,
    input  logic [31:0]                rd_addr,
    output logic                       ret_valid,
    output logic [255:0]               ret_data,

    input  logic                       iucache_ren_i,
    input  logic [31:0]                iucache_addr_i,
    output logic                       iucache_rvalid_o,
    output logic [31:0]                iucache_rdata_o,

    icache_axi_refill_if.master        axi
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_RESP
    } state_t;

    state_t          state_q;
    logic            is_unc_q;
    logic [2:0]      cnt_q;
    logic [7:0][31:0] line_q;
    logic [7:0][31:0] line_nxt;

    // Buffer as it will look once the current beat is stored; used both
    // for the buffer update and for the returned data on the last beat so
    // the final word is not one cycle late.
    always_comb begin
        line_nxt        = line_q;
        line_nxt[cnt_q] = axi.rdata;
    end

    assign axi.arid = AXI_ID;

    // Response status/ID and the sub-line address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{axi.rid, axi.rresp, rd_addr[4:0], iucache_addr_i[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            is_unc_q         <= 1'b0;
            cnt_q            <= 3'd0;
            line_q           <= '0;
            axi.araddr       <= 32'd0;
            axi.arlen        <= 8'd0;
            axi.arsize       <= 3'd0;
            axi.arburst      <= 2'd0;
            axi.arvalid      <= 1'b0;
            axi.rready       <= 1'b0;
            ret_valid        <= 1'b0;
            ret_data         <= '0;
            iucache_rvalid_o <= 1'b0;
            iucache_rdata_o  <= 32'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // Uncached fetch wins over a line refill.
                    if (iucache_ren_i) begin
                        state_q     <= S_AR;
                        is_unc_q    <= 1'b1;
                        cnt_q       <= 3'd0;
                        line_q      <= '0;
                        axi.araddr  <= {iucache_addr_i[31:2], 2'b00};
                        axi.arlen   <= 8'd0;
                        axi.arsize  <= 3'b010;
                        axi.arburst <= 2'b01;
                        axi.arvalid <= 1'b1;
                    end else if (rd_req) begin
                        state_q     <= S_AR;
                        is_unc_q    <= 1'b0;
                        cnt_q       <= 3'd0;
                        line_q      <= '0;
                        axi.araddr  <= {rd_addr[31:5], 5'b00000};
                        axi.arlen   <= 8'd7;
                        axi.arsize  <= 3'b010;
                        axi.arburst <= 2'b01;
                        axi.arvalid <= 1'b1;
                    end
                end

                S_AR: begin
                    if (axi.arready) begin
                        state_q     <= S_R;
                        axi.arvalid <= 1'b0;
                        axi.rready  <= 1'b1;
                    end
                end

                S_R: begin
                    if (axi.rvalid) begin
                        line_q <= line_nxt;
                        cnt_q  <= cnt_q + 3'd1;
                        if (axi.rlast) begin
                            state_q    <= S_RESP;
                            axi.rready <= 1'b0;
                            if (is_unc_q) begin
                                iucache_rvalid_o <= 1'b1;
                                iucache_rdata_o  <= line_nxt[0];
                            end else begin
                                ret_valid <= 1'b1;
                                ret_data  <= line_nxt;
                            end
                        end
                    end
                end

                S_RESP: begin
                    state_q          <= S_IDLE;
                    ret_valid        <= 1'b0;
                    iucache_rvalid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_axi_refill.sv
// Directed testbench for icache_axi_refill: line refill, uncached fetch,
// arbitration, backpressure, early rlast and reset during a burst.
module tb_icache_axi_refill;

    logic         clk = 1'b0;
    logic         reset;
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic         ret_valid;
    logic [255:0] ret_data;
    logic         iucache_ren_i;
    logic [31:0]  iucache_addr_i;
    logic         iucache_rvalid_o;
    logic [31:0]  iucache_rdata_o;

    icache_axi_refill_if axi();

    icache_axi_refill #(.AXI_ID(4'd5)) dut (
        .clk              (clk),
        .reset            (reset),
        .rd_req           (rd_req),
        .rd_addr          (rd_addr),
        .ret_valid        (ret_valid),
        .ret_data         (ret_data),
        .iucache_ren_i    (iucache_ren_i),
        .iucache_addr_i   (iucache_addr_i),
        .iucache_rvalid_o (iucache_rvalid_o),
        .iucache_rdata_o  (iucache_rdata_o),
        .axi              (axi.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_run  = 0;
    int n_fail = 0;
    int c0;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mkline(input logic [31:0] base,
                                            input int n);
        logic [255:0] l;
        l = '0;
        for (int i = 0; i < n; i++) l[32*i +: 32] = base + 32'(i);
        return l;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".arvalid"}, 256'(axi.arvalid), 256'(0));
        chk({tag, ".rready"}, 256'(axi.rready), 256'(0));
        chk({tag, ".ret_valid"}, 256'(ret_valid), 256'(0));
        chk({tag, ".iuc_rvalid"}, 256'(iucache_rvalid_o), 256'(0));
        chk({tag, ".ret_data"}, ret_data, 256'(0));
        chk({tag, ".iuc_rdata"}, 256'(iucache_rdata_o), 256'(0));
        chk({tag, ".araddr"}, 256'(axi.araddr), 256'(0));
        chk({tag, ".arlen"}, 256'(axi.arlen), 256'(0));
        chk({tag, ".arsize"}, 256'(axi.arsize), 256'(0));
        chk({tag, ".arburst"}, 256'(axi.arburst), 256'(0));
        chk({tag, ".arid"}, 256'(axi.arid), 256'(5));
    endtask

    // Entered one cycle after the request was sampled.
    task automatic ar_phase(input int waitc, input logic [31:0] ea,
                            input logic [7:0] el, input string tag);
        chk({tag, ".arvalid"}, 256'(axi.arvalid), 256'(1));
        chk({tag, ".araddr"}, 256'(axi.araddr), 256'(ea));
        chk({tag, ".arlen"}, 256'(axi.arlen), 256'(el));
        chk({tag, ".arsize"}, 256'(axi.arsize), 256'(3'b010));
        chk({tag, ".arburst"}, 256'(axi.arburst), 256'(2'b01));
        for (int i = 0; i < waitc; i++) begin
            tick();
            chk({tag, ".hold_arvalid"}, 256'(axi.arvalid), 256'(1));
            chk({tag, ".hold_araddr"}, 256'(axi.araddr), 256'(ea));
        end
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        chk({tag, ".rready"}, 256'(axi.rready), 256'(1));
        chk({tag, ".ar_done"}, 256'(axi.arvalid), 256'(0));
    endtask

    task automatic r_phase(input int nb, input bit gaps,
                           input logic [31:0] base, input bit last);
        for (int k = 0; k < nb; k++) begin
            axi.rvalid = 1'b1;
            axi.rdata  = base + 32'(k);
            axi.rlast  = last && (k == nb - 1);
            axi.rresp  = 2'(k);
            axi.rid    = 4'(k);
            tick();
            axi.rvalid = 1'b0;
            axi.rlast  = 1'b0;
            axi.rdata  = 32'hBAD0_0000;
            if (gaps && k != nb - 1) begin
                axi.rlast = 1'b1;
                tick();
                axi.rlast = 1'b0;
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        rd_req         = 1'b0;
        rd_addr        = 32'd0;
        iucache_ren_i  = 1'b0;
        iucache_addr_i = 32'd0;
        axi.arready    = 1'b0;
        axi.rid        = 4'd0;
        axi.rdata      = 32'd0;
        axi.rresp      = 2'd0;
        axi.rlast      = 1'b0;
        axi.rvalid     = 1'b0;
        tick();
        tick();
        chk_reset_vals("por");
        reset = 1'b0;
        tick();

        // Line refill, minimum latency
        c0      = cyc;
        rd_req  = 1'b1;
        rd_addr = 32'h1C00_0024;
        tick();
        rd_req = 1'b0;
        ar_phase(0, 32'h1C00_0020, 8'd7, "line");
        r_phase(8, 1'b0, 32'h1000, 1'b1);
        chk("line.ret_valid", 256'(ret_valid), 256'(1));
        chk("line.latency", 256'(cyc - c0), 256'(10));
        chk("line.word0", 256'(ret_data[31:0]), 256'(32'h1000));
        chk("line.word7", 256'(ret_data[255:224]), 256'(32'h1007));
        chk("line.data", ret_data, mkline(32'h1000, 8));
        chk("line.iuc_quiet", 256'(iucache_rvalid_o), 256'(0));
        tick();
        chk("line.pulse_end", 256'(ret_valid), 256'(0));
        chk("line.data_hold", ret_data, mkline(32'h1000, 8));

        // Uncached fetch
        c0             = cyc;
        iucache_ren_i  = 1'b1;
        iucache_addr_i = 32'h1FD0_0007;
        tick();
        iucache_ren_i = 1'b0;
        ar_phase(0, 32'h1FD0_0004, 8'd0, "unc");
        r_phase(1, 1'b0, 32'hDEAD_BEEF, 1'b1);
        chk("unc.rvalid", 256'(iucache_rvalid_o), 256'(1));
        chk("unc.rdata", 256'(iucache_rdata_o), 256'(32'hDEAD_BEEF));
        chk("unc.latency", 256'(cyc - c0), 256'(3));
        chk("unc.no_ret", 256'(ret_valid), 256'(0));
        chk("unc.line_hold", ret_data, mkline(32'h1000, 8));
        tick();
        chk("unc.pulse_end", 256'(iucache_rvalid_o), 256'(0));

        // Simultaneous requests: uncached first, line right after
        rd_req         = 1'b1;
        rd_addr        = 32'h1C00_0040;
        iucache_ren_i  = 1'b1;
        iucache_addr_i = 32'h1FD0_0010;
        tick();
        iucache_ren_i = 1'b0;
        ar_phase(0, 32'h1FD0_0010, 8'd0, "sim_unc");
        r_phase(1, 1'b0, 32'hCAFE_0001, 1'b1);
        chk("sim.iuc_rvalid", 256'(iucache_rvalid_o), 256'(1));
        chk("sim.iuc_rdata", 256'(iucache_rdata_o), 256'(32'hCAFE_0001));
        chk("sim.no_ret", 256'(ret_valid), 256'(0));
        tick();
        chk("sim.idle_arvalid", 256'(axi.arvalid), 256'(0));
        tick();
        rd_req = 1'b0;
        ar_phase(0, 32'h1C00_0040, 8'd7, "sim_line");
        r_phase(8, 1'b0, 32'h2000, 1'b1);
        chk("sim.ret_valid", 256'(ret_valid), 256'(1));
        chk("sim.data", ret_data, mkline(32'h2000, 8));
        tick();

        // Backpressure on AR and gaps on R
        rd_req  = 1'b1;
        rd_addr = 32'h0000_1234;
        tick();
        rd_req = 1'b0;
        ar_phase(5, 32'h0000_1220, 8'd7, "bp");
        r_phase(8, 1'b1, 32'h3000, 1'b1);
        chk("bp.ret_valid", 256'(ret_valid), 256'(1));
        chk("bp.data", ret_data, mkline(32'h3000, 8));
        tick();
        chk("bp.pulse_end", 256'(ret_valid), 256'(0));

        // Early rlast on the fourth beat
        rd_req  = 1'b1;
        rd_addr = 32'h0000_0040;
        tick();
        rd_req = 1'b0;
        ar_phase(0, 32'h0000_0040, 8'd7, "early");
        r_phase(4, 1'b0, 32'h4000, 1'b1);
        chk("early.ret_valid", 256'(ret_valid), 256'(1));
        chk("early.data", ret_data, mkline(32'h4000, 4));
        tick();

        // Reset after beat 4 of a line read
        rd_req  = 1'b1;
        rd_addr = 32'h0000_0080;
        tick();
        rd_req = 1'b0;
        ar_phase(0, 32'h0000_0080, 8'd7, "rst");
        r_phase(5, 1'b0, 32'h5000, 1'b0);
        reset = 1'b1;
        tick();
        chk_reset_vals("mid_rst");
        reset = 1'b0;
        tick();
        tick();
        chk("rst.no_ret", 256'(ret_valid), 256'(0));
        chk("rst.idle", 256'(axi.arvalid), 256'(0));
        rd_req  = 1'b1;
        rd_addr = 32'h0000_0100;
        tick();
        rd_req = 1'b0;
        ar_phase(0, 32'h0000_0100, 8'd7, "fresh");
        r_phase(8, 1'b0, 32'h6000, 1'b1);
        chk("fresh.ret_valid", 256'(ret_valid), 256'(1));
        chk("fresh.data", ret_data, mkline(32'h6000, 8));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_axi_refill.md
# icache_axi_refill

Responder side of the instruction-cache memory interface. Accepts cache-line refill requests (`rd_req`/`rd_addr`) and uncached single-word fetches (`iucache_ren_i`/`iucache_addr_i`) from the icache, turns each into one AXI4 read transaction, and returns either an assembled 256-bit line (`ret_valid`/`ret_data`) or one 32-bit word (`iucache_rvalid_o`/`iucache_rdata_o`). Sits between the icache and the AXI interconnect, with one transaction outstanding at a time.

## Interface
- `AXI_ID`, default 4'd0: constant driven on `arid`.
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `rd_req` in 1: line refill request (level; the icache may hold it for many cycles).
- `rd_addr` in 32: refill address (any byte within the line).
- `ret_valid` out 1: one-cycle pulse; the line is on `ret_data`.
- `ret_data` out 256: line data; word i is at `[32*i+31:32*i]`.
- `iucache_ren_i` in 1: uncached fetch request (level).
- `iucache_addr_i` in 32: uncached fetch address.
- `iucache_rvalid_o` out 1: one-cycle pulse; the word is on `iucache_rdata_o`.
- `iucache_rdata_o` out 32: uncached word.
- `arid` out 4, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arvalid` out 1, `arready` in 1: AXI AR channel.
- `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1: AXI R channel.

## Operation
- FSM states: IDLE, AR, R, RESP.
- **IDLE**
  - If `iucache_ren_i`=1: latch an uncached request, then go to AR. Uncached takes priority over `rd_req` when both are high.
  - Else if `rd_req`=1: latch a line request, then go to AR.
  - Latching clears the beat counter and the line buffer to 0.
- **AR**
  - `arvalid`=1. `araddr`, `arlen`, `arsize` and `arburst` are registered and stay stable until `arready`.
  - Line request: `araddr`={addr[31:5],5'b0}, `arlen`=7.
  - Uncached request: `araddr`={addr[31:2],2'b0}, `arlen`=0.
  - Both cases: `arsize`=3'b010, `arburst`=2'b01 (INCR).
  - Go to R on `arvalid && arready`.
- **R**
  - `rready`=1.
  - On each `rvalid`: beat k is written to buffer word k, and the 3-bit counter increments.
  - `rresp` and `rid` are ignored; data is returned regardless of `rresp`.
  - On `rvalid && rlast`: go to RESP. If `rlast` arrives early, words not yet received stay 0.
- **RESP**
  - Line request: `ret_valid`=1 for exactly one cycle.
  - Uncached request: `iucache_rvalid_o`=1 for exactly one cycle.
  - The data output carries the registered buffer in that cycle.
  - Go to IDLE next cycle.
- Requests in AR, R and RESP are not sampled.
- A request still high in the cycle after RESP starts a new transaction. The icache drops `rd_req` in that cycle by design.
- The block never aborts a transaction. Flush handling (discarding one return) belongs to the icache.
- Outputs hold their last value outside RESP; only the valid pulses return to 0.

## Timing
- Reset values: `arvalid`=0, `rready`=0, `ret_valid`=0, `iucache_rvalid_o`=0, `ret_data`=0, `iucache_rdata_o`=0, `araddr`=0, `arlen`=0, `arsize`=0, `arburst`=0, `arid`=`AXI_ID`. FSM resets to IDLE, counter to 0.
- Reset mid-transaction: return to IDLE next cycle with all outputs at reset values. No AXI drain; reset is system-wide.
- Request sampled in IDLE at cycle 0 → `arvalid` high at cycle 1.
- `arready` at cycle 1 → `rready` high from cycle 2.
- Final beat at cycle n → valid pulse at cycle n+1.
- Minimum line latency (8 back-to-back beats from cycle 2): `ret_valid` at cycle 10.
- Minimum uncached latency: `iucache_rvalid_o` at cycle 3.
- `rvalid` gaps stall the counter with no loss.
- `arready` held low keeps `arvalid` and `araddr` constant indefinitely.

## Test plan
- **Line refill:** `rd_req`=1, `rd_addr`=0x1C00_0024; `arready` immediate; beats 0x1000+k for k=0..7 back-to-back.
  - Expect `araddr`=0x1C00_0020, `arlen`=7, `ret_valid` pulse at cycle 10.
  - Expect `ret_data[31:0]`=0x1000 and `ret_data[255:224]`=0x1007.
- **Uncached:** `iucache_ren_i`=1, addr 0x1FD0_0007; beat 0xDEAD_BEEF.
  - Expect `araddr`=0x1FD0_0004, `arlen`=0.
  - Expect `iucache_rvalid_o` pulse with `iucache_rdata_o`=0xDEAD_BEEF, and `ret_valid` stays 0.
- **Simultaneous requests:** `rd_req` and `iucache_ren_i` high in the same IDLE cycle.
  - Expect the uncached transaction first, then the line read on the cycle after its RESP if `rd_req` is still high.
- **Backpressure:** `arready` low for 5 cycles; `rvalid` toggling 1,0,1,0.
  - Expect `araddr` stable throughout, words placed in order, `ret_valid` 1 cycle after the 8th beat.
- **Early `rlast`:** `rlast` on beat 3 of a line read.
  - Expect `ret_data` words 0–3 equal to the beats and words 4–7 equal to 0.
- **Reset mid-burst:** `reset` asserted after beat 4.
  - Expect all outputs at reset values next cycle, no `ret_valid`, and a fresh `rd_req` accepted after release.
